// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the hazard unit state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_stall_unit_src_use_decode.sv
// Source-register usage decoder; shared with the forwarding logic.
module src_use_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output logic       UsesRs,
  output logic       UsesRt,
  output logic       IsBranch
);

  always_comb begin
    UsesRs   = !((op == OP_J) || (op == OP_JAL) ||
                 ((op == OP_RTYPE) && ((fn == FN_SLL) || (fn == FN_SRL))));
    UsesRt   = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    IsBranch = (op == OP_BEQ) || (op == OP_BNE);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for hazards the forwarding paths cannot cover,
// plus a saturating count of stalled cycles.
module hazard_stall_unit
  import mips_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = 32,
  parameter bit          BRANCH_IN_ID = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [31:0]          ID_Instruction,
  input  logic [4:0]           EX_RegisterRd,
  input  logic                 EX_RegisterWrite,
  input  logic                 EX_MemRead,
  input  logic [4:0]           MEM_RegisterRd,
  input  logic                 MEM_MemRead,
  input  logic                 BranchTaken,
  input  logic                 Jump,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 ID_EX_Bubble,
  output logic                 IF_ID_Flush,
  output logic [CNT_WIDTH-1:0] StallCycleCount
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  logic       uses_rs, uses_rt, is_branch;
  logic       unused_instr_bits;

  assign op = ID_Instruction[31:26];
  assign rs = ID_Instruction[25:21];
  assign rt = ID_Instruction[20:16];
  assign fn = ID_Instruction[5:0];
  assign unused_instr_bits = ^ID_Instruction[15:6];

  src_use_decode u_decode (
    .op       (op),
    .fn       (fn),
    .UsesRs   (uses_rs),
    .UsesRt   (uses_rt),
    .IsBranch (is_branch)
  );

  logic match_ex, match_mem, branch_chk;
  logic need2, need1;

  // $0 is hardwired to zero, so it can never be a real dependency.
  assign match_ex  = (EX_RegisterRd != 5'd0) &&
                     ((uses_rs && (rs == EX_RegisterRd)) ||
                      (uses_rt && (rt == EX_RegisterRd)));
  assign match_mem = (MEM_RegisterRd != 5'd0) &&
                     ((uses_rs && (rs == MEM_RegisterRd)) ||
                      (uses_rt && (rt == MEM_RegisterRd)));

  assign branch_chk = BRANCH_IN_ID && is_branch;
  assign need2 = branch_chk && EX_MemRead && match_ex;
  assign need1 = (EX_MemRead && match_ex) ||
                 (branch_chk && ((EX_RegisterWrite && match_ex) ||
                                 (MEM_MemRead && match_mem)));

  state_t state_q, state_d;
  logic   rem_q, rem_d;
  logic   stall;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (need2) begin
          stall   = 1'b1;
          state_d = HOLD;
          rem_d   = 1'b1;
        end else if (need1) begin
          stall = 1'b1;
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (rem_q != 1'b0) rem_d = rem_q - 1'b1;
        if (rem_d == 1'b0) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        rem_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      rem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    PCWrite      = Rst || !stall;
    IF_ID_Write  = Rst || !stall;
    ID_EX_Bubble = !Rst && stall;
    IF_ID_Flush  = !Rst && !stall && (BranchTaken || Jump);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCycleCount <= '0;
    end else if (!PCWrite && (StallCycleCount != '1)) begin
      StallCycleCount <= StallCycleCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench: the driver queues expected outputs per cycle, a
// negedge monitor pops and compares them against the DUT.
module tb_hazard_stall_unit;

  localparam int unsigned CW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [31:0]   ID_Instruction;
  logic [4:0]    EX_RegisterRd;
  logic          EX_RegisterWrite;
  logic          EX_MemRead;
  logic [4:0]    MEM_RegisterRd;
  logic          MEM_MemRead;
  logic          BranchTaken;
  logic          Jump;
  logic          PCWrite;
  logic          IF_ID_Write;
  logic          ID_EX_Bubble;
  logic          IF_ID_Flush;
  logic [CW-1:0] StallCycleCount;

  hazard_stall_unit #(.CNT_WIDTH(CW), .BRANCH_IN_ID(1'b1)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .ID_Instruction   (ID_Instruction),
    .EX_RegisterRd    (EX_RegisterRd),
    .EX_RegisterWrite (EX_RegisterWrite),
    .EX_MemRead       (EX_MemRead),
    .MEM_RegisterRd   (MEM_RegisterRd),
    .MEM_MemRead      (MEM_MemRead),
    .BranchTaken      (BranchTaken),
    .Jump             (Jump),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .ID_EX_Bubble     (ID_EX_Bubble),
    .IF_ID_Flush      (IF_ID_Flush),
    .StallCycleCount  (StallCycleCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string         name;
    logic          pcw;
    logic          ifw;
    logic          bub;
    logic          flu;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic drive(input string name, input logic rst, input logic [31:0] ins,
                       input logic [4:0] exrd, input logic exrw, input logic exmr,
                       input logic [4:0] memrd, input logic memmr,
                       input logic bt, input logic jmp,
                       input logic exp_stall, input logic exp_flush, input int exp_cnt);
    exp_t e;
    @(posedge Clk);
    #1;
    Rst = rst; ID_Instruction = ins;
    EX_RegisterRd = exrd; EX_RegisterWrite = exrw; EX_MemRead = exmr;
    MEM_RegisterRd = memrd; MEM_MemRead = memmr;
    BranchTaken = bt; Jump = jmp;
    e.name = name;
    e.pcw  = !exp_stall;
    e.ifw  = !exp_stall;
    e.bub  = exp_stall;
    e.flu  = exp_flush;
    e.cnt  = CW'(exp_cnt);
    q.push_back(e);
  endtask

  task automatic idle(input string name, input int exp_cnt);
    drive(name, 1'b0, NOP, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [CW+3:0] act, req;
      e   = q.pop_front();
      act = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, StallCycleCount};
      req = {e.pcw, e.ifw, e.bub, e.flu, e.cnt};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: got pcw=%b ifw=%b bub=%b flush=%b cnt=%0d, expected pcw=%b ifw=%b bub=%b flush=%b cnt=%0d",
                 e.name, PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, StallCycleCount,
                 e.pcw, e.ifw, e.bub, e.flu, e.cnt);
      end
    end
  end

  initial begin
    Rst = 1'b1; ID_Instruction = NOP;
    EX_RegisterRd = 5'd0; EX_RegisterWrite = 1'b0; EX_MemRead = 1'b0;
    MEM_RegisterRd = 5'd0; MEM_MemRead = 1'b0;
    BranchTaken = 1'b0; Jump = 1'b0;
    repeat (2) @(posedge Clk);

    // Reset forces released outputs even with a hazard and a taken branch present.
    drive("reset_forced", 1'b1, rtype(5'd8, 5'd10, 5'd9, 6'h20), 5'd8, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Load-use on an ALU op: one bubble.
    drive("lu_stall",   1'b0, rtype(5'd8, 5'd10, 5'd9, 6'h20), 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    drive("lu_release", 1'b0, rtype(5'd8, 5'd10, 5'd9, 6'h20), 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    idle("lu_idle", 1);

    // Load feeding a branch: two stall cycles, second ignores changed EX inputs.
    drive("br_ld_s1",   1'b0, itype(6'b000100, 5'd8, 5'd3), 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    drive("br_ld_hold", 1'b0, itype(6'b000100, 5'd8, 5'd3), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    drive("br_ld_rel",  1'b0, itype(6'b000100, 5'd8, 5'd3), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    idle("br_ld_idle", 3);

    // $0 destination never stalls.
    drive("reg0_nostall", 1'b0, rtype(5'd0, 5'd0, 5'd9, 6'h20), 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Taken branch without hazard flushes once; with an ALU hazard flush waits for release.
    drive("br_flush",     1'b0, itype(6'b000100, 5'd5, 5'd6), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    idle("br_flush_idle", 3);
    drive("br_alu_stall", 1'b0, itype(6'b000100, 5'd5, 5'd6), 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    drive("br_alu_rel",   1'b0, itype(6'b000100, 5'd5, 5'd6), 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4);

    // Decoder corner cases.
    drive("jump_no_rs",  1'b0, {6'b000010, 5'd8, 21'd0}, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4);
    drive("sw_rt_stall", 1'b0, itype(6'b101011, 5'd2, 5'd8), 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    idle("sw_idle", 5);
    drive("sll_no_rs",   1'b0, rtype(5'd8, 5'd1, 5'd9, 6'h00), 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    drive("mem_ld_alu",  1'b0, rtype(5'd8, 5'd10, 5'd9, 6'h20), 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    drive("mem_ld_br",   1'b0, itype(6'b000101, 5'd3, 5'd8), 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    idle("mem_ld_idle", 6);

    // Reset during HOLD abandons the second stall cycle.
    drive("rst_hold_s1", 1'b0, itype(6'b000100, 5'd8, 5'd3), 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6);
    drive("rst_hold_rst",1'b1, itype(6'b000100, 5'd8, 5'd3), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    drive("rst_hold_run",1'b0, itype(6'b000100, 5'd8, 5'd3), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Continuous load-use stall saturates the 4-bit counter.
    for (int k = 0; k < 18; k++) begin
      drive("sat_stall", 1'b0, rtype(5'd8, 5'd10, 5'd9, 6'h20), 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (k > 15) ? 15 : k);
    end
    idle("sat_hold", 15);
    idle("sat_hold2", 15);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge Clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
